serial_frame_tx: RTL and testbench

Parallel-to-serial framed transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single line, one bit per DIV clock cycles. Each frame is a start bit, then the data LSB first, then a stop bit. The block is the transmit end of the team's single-wire serial link and feeds the flop-based capture/receive path built from the existing dff primitives.

---
 rtl/serial_frame_tx.sv | 141 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed parallel-to-serial transmitter.
// A WIDTH-bit word accepted over valid/ready is sent on a single line as
// one start bit (0), WIDTH data bits LSB first, and one stop bit (1),
// each bit held for DIV clock cycles. The line idles high.
module serial_frame_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             busy,
  output logic             done
);

  // Counter widths never drop below one bit so DIV=1 / WIDTH=1 still
  // have a real register to compare against the terminal count of zero.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_chk
    $error("serial_frame_tx: WIDTH must be in 1..32");
  end
  if (DIV < 1 || DIV > 1024) begin : g_div_chk
    $error("serial_frame_tx: DIV must be in 1..1024");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               q_q, q_d;
  logic               done_q, done_d;

  logic               div_last;

  // End of the current bit period.
  assign div_last = (div_cnt_q == DIV_LAST);

  // Handshake and status come straight from the state register.
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign q          = q_q;
  assign done       = done_q;

  // Frame sequencing: next state, shift register and counters.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // In IDLE load_ready is high, so load_valid alone completes a handshake.
        if (load_valid) begin
          sh_d      = d;
          div_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (div_last) begin
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (div_last) begin
          sh_d      = sh_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level is decoded from the upcoming state so the registered q
  // lines up exactly with the state it belongs to, with no glitches.
  always_comb begin
    q_d = 1'b1;
    unique case (state_d)
      START:   q_d = 1'b0;
      DATA:    q_d = sh_d[0];
      default: q_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      q_q       <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      q_q       <= q_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a WIDTH=8/DIV=4 instance checked through a
// scoreboard plus a WIDTH=1/DIV=1 corner instance checked directly.
module tb_serial_frame_tx;

  localparam int W_M   = 8;
  localparam int DIV_M = 4;
  localparam int FLEN  = (W_M + 2) * DIV_M;

  logic           clk = 1'b0;
  logic           res;
  logic [W_M-1:0] d;
  logic           load_valid;
  logic           load_ready, q, busy, done;

  logic           dc_d, dc_valid;
  logic           dc_ready, dc_q, dc_busy, dc_done;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(W_M), .DIV(DIV_M)) dut (
    .clk(clk), .res(res), .d(d), .load_valid(load_valid),
    .load_ready(load_ready), .q(q), .busy(busy), .done(done)
  );

  serial_frame_tx #(.WIDTH(1), .DIV(1)) dut_c (
    .clk(clk), .res(res), .d(dc_d), .load_valid(dc_valid),
    .load_ready(dc_ready), .q(dc_q), .busy(dc_busy), .done(dc_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: the line level in every cycle of a frame, from the framing rule.
  function automatic logic [63:0] exp_frame(input logic [W_M-1:0] w);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < FLEN; c++) begin
      int b;
      b = c / DIV_M;
      if (b == 0)            r[c] = 1'b0;
      else if (b == W_M + 1) r[c] = 1'b1;
      else                   r[c] = w[b-1];
    end
    return r;
  endfunction

  // Scoreboard state
  logic [W_M-1:0] sb_q[$];
  int n_sent = 0, n_aborted = 0;
  int frames_done = 0, done_seen = 0;
  int idle_err = 0, busy_err = 0;
  int idle_cnt = 0, last_gap = 0, pos = 0;
  bit in_frame = 1'b0, at_end = 1'b0;
  logic [63:0] cap;
  logic [W_M-1:0] cur;

  // Monitor: frames start when busy rises; capture the line per cycle and
  // compare to the queued word's expected waveform.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (res) begin
      in_frame = 1'b0;
      at_end   = 1'b0;
      idle_cnt = 0;
    end else if (at_end) begin
      at_end = 1'b0;
      check("frame_q", cap, exp_frame(cur));
      check("frame_end", {60'd0, busy, load_ready, done, q}, 64'b0111);
      frames_done++;
      idle_cnt = 1;
    end else if (in_frame) begin
      cap[pos] = q;
      if (!busy) busy_err++;
      pos++;
      if (pos == FLEN) begin
        in_frame = 1'b0;
        at_end   = 1'b1;
      end
    end else if (busy) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame: frame started, got none queued, expected no frame");
        cur = '0;
      end else begin
        cur = sb_q.pop_front();
      end
      last_gap = idle_cnt;
      cap      = '0;
      cap[0]   = q;
      pos      = 1;
      in_frame = 1'b1;
    end else begin
      idle_cnt++;
      if (q !== 1'b1) idle_err++;
    end
  end

  // Present a word and hold valid until accepted; push the expectation
  // at the edge where the handshake completes.
  task automatic send(input logic [W_M-1:0] w, input bit hold);
    int t;
    t = 0;
    @(negedge clk);
    d = w;
    load_valid = 1'b1;
    while (!load_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_checks++;
      $display("FAIL send_timeout: got load_ready=0 for %0d cycles, expected 1", t);
    end else begin
      sb_q.push_back(w);
      n_sent++;
    end
    @(posedge clk);
    #1;
    if (!hold) load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk); #1;
    while ((busy || in_frame || at_end || sb_q.size() != 0) && t < 5000) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 5000) begin
      n_checks++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", t);
    end
  endtask

  initial begin
    int fr0, dn0;
    logic [2:0] seq, bz, dn;
    res = 1'b1; load_valid = 1'b0; d = '0; dc_valid = 1'b0; dc_d = 1'b0;
    #1;
    check("reset_state", {56'd0, q, load_ready, busy, done, dc_q, dc_ready, dc_busy, dc_done},
          64'b1100_1100);
    repeat (2) @(negedge clk);
    res = 1'b0;

    // Single frame A5
    fr0 = frames_done; dn0 = done_seen;
    send(8'hA5, 1'b0);
    wait_idle();
    check("single_frames", frames_done - fr0, 1);
    check("single_done", done_seen - dn0, 1);

    // Back-to-back with valid held
    fr0 = frames_done; dn0 = done_seen;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    wait_idle();
    check("b2b_frames", frames_done - fr0, 2);
    check("b2b_done", done_seen - dn0, 2);
    check("b2b_gap", last_gap, 1);

    // Valid while busy is ignored; d changes mid-frame have no effect
    fr0 = frames_done;
    send(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    d = 8'hFF; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (5) @(negedge clk);
    d = 8'h00;
    wait_idle();
    repeat (5) @(negedge clk);
    check("ignore_busy_line", busy, 0);
    check("ignore_frames", frames_done - fr0, 1);

    // Reset during data bit 3 of 0x55, with load_valid asserted alongside
    dn0 = done_seen;
    send(8'h55, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    check("pre_reset_bit3", q, 0);
    res = 1'b1; d = 8'hFF; load_valid = 1'b1;
    n_aborted++;
    #1;
    check("async_reset", {60'd0, q, load_ready, busy, done}, 64'b1100);
    repeat (3) @(negedge clk);
    check("held_reset", {60'd0, q, load_ready, busy, done}, 64'b1100);
    res = 1'b0; load_valid = 1'b0;
    sb_q.delete();
    check("abort_no_done", done_seen - dn0, 0);
    fr0 = frames_done;
    send(8'h81, 1'b0);
    wait_idle();
    check("post_reset_frames", frames_done - fr0, 1);

    // Randomized traffic with gaps and stray valid pulses while busy
    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(0, 4);
      repeat (gap) @(negedge clk);
      send(W_M'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        d = W_M'($urandom); load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        d = W_M'($urandom);
      end
    end
    wait_idle();

    // Corner instance WIDTH=1, DIV=1
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      dc_d = v[0]; dc_valid = 1'b1;
      @(posedge clk); #1;
      dc_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        seq[c] = dc_q; bz[c] = dc_busy; dn[c] = dc_done;
      end
      @(negedge clk);
      check("corner_seq", seq, {1'b1, v[0], 1'b0});
      check("corner_busy", bz, 3'b111);
      check("corner_end", {dn, dc_done, dc_ready, dc_busy, dc_q}, 7'b000_1101);
    end

    check("sb_empty", sb_q.size(), 0);
    check("frames_total", frames_done, n_sent - n_aborted);
    check("done_pulses", done_seen, frames_done);
    check("idle_line", idle_err, 0);
    check("busy_in_frame", busy_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
